// File: rtl/color_cmd_parser.sv
// UART colour command parser: A5, idx, R, G, B [, chk] frames update one of four held RGB registers.
// Define COLOR_CMD_CHECKSUM_EN to require a trailing XOR checksum byte (6-byte frames).
module color_cmd_parser #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [3:0]  color_valid,
    output logic [23:0] rgb0,
    output logic [23:0] rgb1,
    output logic [23:0] rgb2,
    output logic [23:0] rgb3,
    output logic        frame_err,
    output logic        busy
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_IDX  = 3'd1;
    localparam logic [2:0] ST_RED  = 3'd2;
    localparam logic [2:0] ST_GRN  = 3'd3;
    localparam logic [2:0] ST_BLU  = 3'd4;
`ifdef COLOR_CMD_CHECKSUM_EN
    localparam logic [2:0] ST_CHK  = 3'd5;
`endif

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam logic [23:0] RGB0_RST  = 24'hff0000;
    localparam logic [23:0] RGB1_RST  = 24'h00ff00;
    localparam logic [23:0] RGB2_RST  = 24'h0000ff;
    localparam logic [23:0] RGB3_RST  = 24'hffff00;

`ifdef COLOR_CMD_CHECKSUM_EN
    function automatic logic [7:0] frame_chk(input logic [1:0] idx,
                                             input logic [7:0] r,
                                             input logic [7:0] g,
                                             input logic [7:0] b);
        return {6'b000000, idx} ^ r ^ g ^ b;
    endfunction
`endif

    function automatic logic [3:0] idx_onehot(input logic [1:0] idx);
        logic [3:0] oh;
        case (idx)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    logic [2:0]  state_r;
    logic [2:0]  state_nxt_s;
    logic [23:0] cnt_r;
    logic [1:0]  idx_r;
    logic [7:0]  red_r;
    logic [7:0]  grn_r;
`ifdef COLOR_CMD_CHECKSUM_EN
    logic [7:0]  blu_r;
`endif
    logic [3:0]  color_valid_r;
    logic        frame_err_r;
    logic        busy_r;
    logic [23:0] rgb0_r;
    logic [23:0] rgb1_r;
    logic [23:0] rgb2_r;
    logic [23:0] rgb3_r;

    logic        commit_s;
    logic        reject_s;
    logic        timeout_s;
    logic [23:0] commit_rgb_s;

    assign color_valid = color_valid_r;
    assign frame_err   = frame_err_r;
    assign busy        = busy_r;
    assign rgb0        = rgb0_r;
    assign rgb1        = rgb1_r;
    assign rgb2        = rgb2_r;
    assign rgb3        = rgb3_r;

    // Next-state decode, commit/reject qualification and inter-byte timeout detection
    always_comb begin
        state_nxt_s  = state_r;
        commit_s     = 1'b0;
        reject_s     = 1'b0;
        timeout_s    = (state_r != ST_IDLE) && !rx_valid && (cnt_r == (TIMEOUT_CYCLES - 24'd1));
`ifdef COLOR_CMD_CHECKSUM_EN
        commit_rgb_s = {red_r, grn_r, blu_r};
`else
        commit_rgb_s = {red_r, grn_r, rx_data};
`endif
        case (state_r)
            ST_IDLE: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_nxt_s = ST_IDX;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_IDX: begin
                if (rx_valid) begin
                    if (rx_data > 8'd3) begin
                        reject_s    = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_RED;
                    end
                end else begin
                    state_nxt_s = ST_IDX;
                end
            end
            ST_RED: begin
                if (rx_valid) begin
                    state_nxt_s = ST_GRN;
                end else begin
                    state_nxt_s = ST_RED;
                end
            end
            ST_GRN: begin
                if (rx_valid) begin
                    state_nxt_s = ST_BLU;
                end else begin
                    state_nxt_s = ST_GRN;
                end
            end
            ST_BLU: begin
                if (rx_valid) begin
`ifdef COLOR_CMD_CHECKSUM_EN
                    state_nxt_s = ST_CHK;
`else
                    commit_s    = 1'b1;
                    state_nxt_s = ST_IDLE;
`endif
                end else begin
                    state_nxt_s = ST_BLU;
                end
            end
`ifdef COLOR_CMD_CHECKSUM_EN
            ST_CHK: begin
                if (rx_valid) begin
                    if (rx_data == frame_chk(idx_r, red_r, grn_r, blu_r)) begin
                        commit_s = 1'b1;
                    end else begin
                        reject_s = 1'b1;
                    end
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CHK;
                end
            end
`endif
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        // Timeout only fires on a cycle without a byte, so it never collides with commit
        if (timeout_s) begin
            state_nxt_s = ST_IDLE;
            reject_s    = 1'b1;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // FSM state, busy flag and inter-byte idle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= 24'd0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            if (rx_valid || (state_nxt_s == ST_IDLE)) begin
                cnt_r <= 24'd0;
            end else begin
                cnt_r <= cnt_r + 24'd1;
            end
        end
    end

    // Index and shadow colour capture; shadows are dropped on any rejected frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_r <= 2'd0;
            red_r <= 8'd0;
            grn_r <= 8'd0;
`ifdef COLOR_CMD_CHECKSUM_EN
            blu_r <= 8'd0;
`endif
        end else if (reject_s) begin
            idx_r <= 2'd0;
            red_r <= 8'd0;
            grn_r <= 8'd0;
`ifdef COLOR_CMD_CHECKSUM_EN
            blu_r <= 8'd0;
`endif
        end else if (rx_valid) begin
            case (state_r)
                ST_IDX:  idx_r <= rx_data[1:0];
                ST_RED:  red_r <= rx_data;
                ST_GRN:  grn_r <= rx_data;
`ifdef COLOR_CMD_CHECKSUM_EN
                ST_BLU:  blu_r <= rx_data;
`endif
                default: idx_r <= idx_r;
            endcase
        end else begin
            idx_r <= idx_r;
        end
    end

    // Single-cycle status pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            color_valid_r <= 4'b0000;
            frame_err_r   <= 1'b0;
        end else begin
            color_valid_r <= commit_s ? idx_onehot(idx_r) : 4'b0000;
            frame_err_r   <= reject_s;
        end
    end

    // Held colour registers; only the committed index is written
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb0_r <= RGB0_RST;
            rgb1_r <= RGB1_RST;
            rgb2_r <= RGB2_RST;
            rgb3_r <= RGB3_RST;
        end else if (commit_s) begin
            case (idx_r)
                2'd0:    rgb0_r <= commit_rgb_s;
                2'd1:    rgb1_r <= commit_rgb_s;
                2'd2:    rgb2_r <= commit_rgb_s;
                2'd3:    rgb3_r <= commit_rgb_s;
                default: rgb0_r <= rgb0_r;
            endcase
        end else begin
            rgb0_r <= rgb0_r;
        end
    end

endmodule

// File: tb/tb_color_cmd_parser.sv
// Directed self-checking bench for color_cmd_parser; follows COLOR_CMD_CHECKSUM_EN for frame length.
module tb_color_cmd_parser;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [3:0]  color_valid;
    logic [23:0] rgb0, rgb1, rgb2, rgb3;
    logic        frame_err;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int n_err_pulses = 0;
    int n_cv_pulses = 0;
    logic [23:0] model [4];

    typedef struct {
        logic [7:0]  idx;
        logic [23:0] rgb;
        logic [7:0]  chk;
        logic [3:0]  exp_cv;
        logic        exp_err;
    } vec_t;
    vec_t vecs [7];

    color_cmd_parser #(.TIMEOUT_CYCLES(24'd16)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .color_valid(color_valid), .rgb0(rgb0), .rgb1(rgb1), .rgb2(rgb2), .rgb3(rgb3),
        .frame_err(frame_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_rgbs(input string tag);
        check({tag, "_rgb0"}, {8'd0, rgb0}, {8'd0, model[0]});
        check({tag, "_rgb1"}, {8'd0, rgb1}, {8'd0, model[1]});
        check({tag, "_rgb2"}, {8'd0, rgb2}, {8'd0, model[2]});
        check({tag, "_rgb3"}, {8'd0, rgb3}, {8'd0, model[3]});
    endtask

    task automatic reset_model();
        model[0] = 24'hff0000;
        model[1] = 24'h00ff00;
        model[2] = 24'h0000ff;
        model[3] = 24'hffff00;
    endtask

    // Pulse counting plus one-hot / mutual-exclusion check whenever any pulse is seen
    always @(negedge clk) begin
        if (rst && ((color_valid != 4'b0000) || frame_err)) begin
            n_err_pulses += (frame_err ? 1 : 0);
            n_cv_pulses  += $countones(color_valid);
            check("pulse_onehot", $countones({color_valid, frame_err}), 32'd1);
        end
    end

    initial begin
        int e0, c0;
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reset_model();

        vecs[0] = '{8'h02, 24'h123456, 8'h72, 4'b0100, 1'b0};
`ifdef COLOR_CMD_CHECKSUM_EN
        vecs[1] = '{8'h01, 24'h123456, 8'h00, 4'b0000, 1'b1};
`else
        vecs[1] = '{8'h01, 24'h123456, 8'h00, 4'b0010, 1'b0};
`endif
        vecs[2] = '{8'h07, 24'h000000, 8'h00, 4'b0000, 1'b1};
        vecs[3] = '{8'h00, 24'ha5a5a5, 8'ha5, 4'b0001, 1'b0};
        vecs[4] = '{8'h03, 24'h0ff001, 8'hfd, 4'b1000, 1'b0};
        vecs[5] = '{8'h04, 24'h000000, 8'h00, 4'b0000, 1'b1};
`ifdef COLOR_CMD_CHECKSUM_EN
        vecs[6] = '{8'h02, 24'h000000, 8'h03, 4'b0000, 1'b1};
`else
        vecs[6] = '{8'h02, 24'h000000, 8'h03, 4'b0100, 1'b0};
`endif

        repeat (3) @(negedge clk);
        check("rst_cv", {28'd0, color_valid}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check_rgbs("rst");
        rst = 1'b1;
        idle(2);

        // Stray bytes in IDLE are ignored
        drive(8'h12);
        drive(8'h00);
        check("idle_stray_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            drive(8'hA5);
            check("vec_busy_hdr", {31'd0, busy}, 32'd1);
            drive(vecs[i].idx);
            if (vecs[i].idx <= 8'd3) begin
                drive(vecs[i].rgb[23:16]);
                drive(vecs[i].rgb[15:8]);
                drive(vecs[i].rgb[7:0]);
`ifdef COLOR_CMD_CHECKSUM_EN
                drive(vecs[i].chk);
`endif
            end
            check($sformatf("vec%0d_cv", i), {28'd0, color_valid}, {28'd0, vecs[i].exp_cv});
            check($sformatf("vec%0d_err", i), {31'd0, frame_err}, {31'd0, vecs[i].exp_err});
            idle(1);
            check($sformatf("vec%0d_cv_off", i), {28'd0, color_valid}, 32'd0);
            check($sformatf("vec%0d_err_off", i), {31'd0, frame_err}, 32'd0);
            check($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd0);
            if (vecs[i].exp_cv != 4'b0000) model[vecs[i].idx[1:0]] = vecs[i].rgb;
            check_rgbs($sformatf("vec%0d", i));
        end

        // Timeout: 15 idle cycles keep the frame, the 16th aborts it
        e0 = n_err_pulses;
        c0 = n_cv_pulses;
        drive(8'hA5);
        drive(8'h00);
        idle(15);
        check("to_busy_before", {31'd0, busy}, 32'd1);
        check("to_err_before", {31'd0, frame_err}, 32'd0);
        idle(1);
        check("to_err", {31'd0, frame_err}, 32'd1);
        check("to_busy_after", {31'd0, busy}, 32'd0);
        idle(4);
        check("to_err_count", n_err_pulses - e0, 32'd1);
        check("to_no_commit", n_cv_pulses - c0, 32'd0);
        check_rgbs("to");

        // Byte arriving on the limit cycle is accepted
        drive(8'hA5);
        drive(8'h00);
        idle(15);
        drive(8'h34);
        check("lim_busy", {31'd0, busy}, 32'd1);
        check("lim_err", {31'd0, frame_err}, 32'd0);
        drive(8'h56);
        drive(8'h78);
`ifdef COLOR_CMD_CHECKSUM_EN
        drive(8'h1a);
`endif
        check("lim_cv", {28'd0, color_valid}, 32'd1);
        model[0] = 24'h345678;
        idle(1);
        check_rgbs("lim");

        // Back-to-back frames with no gap
        drive(8'hA5); drive(8'h00); drive(8'h11); drive(8'h22); drive(8'h33);
`ifdef COLOR_CMD_CHECKSUM_EN
        drive(8'h00);
`endif
        check("b2b_cv0", {28'd0, color_valid}, 32'h1);
        drive(8'hA5);
        check("b2b_cv0_off", {28'd0, color_valid}, 32'd0);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        drive(8'h03); drive(8'h44); drive(8'h55); drive(8'h66);
`ifdef COLOR_CMD_CHECKSUM_EN
        drive(8'h74);
`endif
        check("b2b_cv3", {28'd0, color_valid}, 32'h8);
        idle(1);
        check("b2b_cv3_off", {28'd0, color_valid}, 32'd0);
        model[0] = 24'h112233;
        model[3] = 24'h445566;
        check_rgbs("b2b");

        // Reset in mid-frame abandons it silently
        e0 = n_err_pulses;
        drive(8'hA5); drive(8'h01); drive(8'h12);
        rst = 1'b0;
        #1;
        reset_model();
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_cv", {28'd0, color_valid}, 32'd0);
        check("mrst_err", {31'd0, frame_err}, 32'd0);
        check_rgbs("mrst");
        idle(2);
        rst = 1'b1;
        drive(8'h34);
        check("mrst_stray_busy0", {31'd0, busy}, 32'd0);
        drive(8'h56);
        check("mrst_stray_busy1", {31'd0, busy}, 32'd0);
        idle(3);
        check("mrst_no_err", n_err_pulses - e0, 32'd0);
        check_rgbs("mrst_post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
